// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory controller port.
// Optional macro ROUND_ROBIN_EN: alternate winners on a tie instead of fixed load/store priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [LEN-1:0]        if_inst,
  input  logic [1:0]            ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [LEN-1:0]        ls_wdata,
  output logic                  ls_ready,
  output logic [LEN-1:0]        ls_rdata,
  output logic [1:0]            ctl_op,
  output logic [ADDR_WIDTH-1:0] ctl_addr,
  output logic [LEN-1:0]        ctl_wdata,
  input  logic [1:0]            ctl_status,
  input  logic [LEN-1:0]        ctl_inst,
  input  logic [LEN-1:0]        ctl_rdata,
  output logic                  err_timeout,
  output logic                  last_grant
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_INST   = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_WRITE  = 2'b11;
  localparam logic [1:0] ST_IF_FIN = 2'b10;
  localparam logic [1:0] ST_RW_FIN = 2'b11;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      op_q;
  logic [WD_W-1:0] wd_cnt;

  logic if_pend;
  logic ls_pend;
  logic grant_ls;
  logic fin_match;
  logic wd_expire;

  assign if_pend = if_req;
  // Encoding 11 on ls_req is treated as no request.
  assign ls_pend = (ls_req == 2'b01) || (ls_req == 2'b10);

`ifdef ROUND_ROBIN_EN
  assign grant_ls = ls_pend && (!if_pend || !last_grant);
`else
  assign grant_ls = ls_pend;
`endif

  assign fin_match = (op_q == OP_INST) ? (ctl_status == ST_IF_FIN)
                                       : (ctl_status == ST_RW_FIN);
  assign wd_expire = (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    ctl_op    = OP_NOP;
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (if_pend || ls_pend) state_nxt = ISSUE;
      end
      ISSUE: begin
        ctl_op    = op_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (fin_match)      state_nxt = DONE;
        else if (wd_expire) state_nxt = IDLE;
      end
      DONE: begin
        if_ready  = (op_q == OP_INST);
        ls_ready  = (op_q == OP_READ) || (op_q == OP_WRITE);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_NOP;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      last_grant  <= 1'b1;
      ctl_addr    <= '0;
      ctl_wdata   <= '0;
      if_inst     <= '0;
      ls_rdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (if_pend || ls_pend) begin
            last_grant <= grant_ls;
            if (grant_ls) begin
              op_q      <= (ls_req == 2'b10) ? OP_WRITE : OP_READ;
              ctl_addr  <= ls_addr;
              ctl_wdata <= ls_wdata;
            end else begin
              op_q     <= OP_INST;
              ctl_addr <= if_addr;
            end
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          // A completion wins over the watchdog when both land on the same cycle.
          if (fin_match) begin
            if (op_q == OP_INST)      if_inst  <= ctl_inst;
            else if (op_q == OP_READ) ls_rdata <= ctl_rdata;
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, the memory address width.
REQ-002 SHALL have parameter LEN, default 32, the data/instruction word width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before a watchdog error.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 if_req  input  1  fetch request (level), held until if_ready.
REQ-007 if_addr  input  ADDR_WIDTH  fetch address.
REQ-008 if_ready  output  1  one-cycle pulse; if_inst valid.
REQ-009 if_inst  output  LEN  fetched instruction.
REQ-010 ls_req  input  2  load/store request (level): 00 none, 01 read, 10 write, 11 treated as none.
REQ-011 ls_addr  input  ADDR_WIDTH  load/store address.
REQ-012 ls_wdata  input  LEN  store data.
REQ-013 ls_ready  output  1  one-cycle pulse; ls_rdata valid for reads, store complete for writes.
REQ-014 ls_rdata  output  LEN  loaded word.
REQ-015 ctl_op  output  2  op to memory controller: 00 NOP, 01 READ_INST, 10 READ_DATA, 11 WRITE.
REQ-016 ctl_addr  output  ADDR_WIDTH  address to controller.
REQ-017 ctl_wdata  output  LEN  store data to controller.
REQ-018 ctl_status  input  2  controller status: 00 RESTING, 01 WORKING, 10 IF_FINISHED, 11 R_W_FINISHED.
REQ-019 ctl_inst, ctl_rdata  input  LEN each  controller result words, valid with the matching FINISHED status.
REQ-020 err_timeout  output  1  sticky watchdog error flag.
REQ-021 last_grant  output  1  0 = fetch granted last, 1 = load/store granted last.

Function
REQ-022 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE: if any request is pending, select the winner, register its op/address/data, go to ISSUE; else stay.
REQ-024 ISSUE: drive ctl_op = selected op for exactly one cycle, then go to WAIT; ctl_op = NOP in every other state.
REQ-025 ctl_addr/ctl_wdata SHALL hold their registered values from ISSUE through DONE.
REQ-026 WAIT: on ctl_status = IF_FINISHED (fetch) or R_W_FINISHED (read/write), capture ctl_inst or ctl_rdata, go to DONE.
REQ-027 A FINISHED code not matching the granted requester's type SHALL be ignored.
REQ-028 DONE: pulse the winner's ready for one cycle with its result held on if_inst/ls_rdata, then go to IDLE; re-arbitration is never in DONE.
REQ-029 Latency: request seen in IDLE at cycle N -> ctl_op at N+1 -> ready at (FINISHED cycle)+1; minimum 4 cycles from IDLE to ready.
REQ-030 Requester SHALL drop the request the cycle after ready; a request dropped or changed after grant SHALL NOT abort the transaction, and ready still pulses.
REQ-031 if_inst and ls_rdata SHALL hold their last captured value until the next capture.
REQ-032 Simultaneous if_req and ls_req in IDLE: arbitration per REQ-038/039; last_grant updates on every grant.
REQ-033 Watchdog: count WAIT cycles; when the count reaches TIMEOUT, set err_timeout, go to IDLE with no ready pulse.
REQ-034 err_timeout SHALL clear only on rst.

Reset
REQ-035 On rst: FSM to IDLE, ctl_op = NOP, if_ready = ls_ready = 0, err_timeout = 0, last_grant = 1, watchdog = 0, ctl_addr/ctl_wdata/if_inst/ls_rdata = 0.
REQ-036 rst mid-transaction SHALL abandon it with no ready pulse; requesters re-request after reset.
REQ-037 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-038 With ROUND_ROBIN_EN defined: on a tie, the requester not in last_grant wins (fetch wins the first tie after reset).
REQ-039 Without ROUND_ROBIN_EN: ls_req always beats if_req; last_grant is still maintained.

Verification
REQ-040 Single fetch: if_req=1, if_addr=0x00010, controller returns IF_FINISHED with ctl_inst=0x00500093 -> one ctl_op=01 pulse with ctl_addr=0x00010; if_ready pulses once with if_inst=0x00500093.
REQ-041 Store: ls_req=10, ls_addr=0x01000, ls_wdata=0xDEADBEEF -> ctl_op=11 for one cycle, ctl_wdata=0xDEADBEEF; ls_ready pulses after R_W_FINISHED; if_ready stays 0.
REQ-042 Tie, both builds: if_req=1 and ls_req=01 together, held -> ROUND_ROBIN_EN build: grants fetch, load, fetch; other build: grants load every time.
REQ-043 Timeout: grant a read, hold ctl_status=WORKING for 20 cycles -> err_timeout=1 after 15 WAIT cycles, FSM in IDLE, no ls_ready; stays 1 until rst.
REQ-044 Reset mid-WAIT: rst=1 one cycle during a fetch -> no if_ready, ctl_op=NOP, outputs at reset values; a fresh if_req then completes normally.
REQ-045 Mismatched status: fetch granted, controller returns R_W_FINISHED -> ignored, still WAIT; a later IF_FINISHED completes the fetch.
